// File: rtl/led_pwm_bank_if.sv
`timescale 1ns/1ps
// PicoSoC iomem bus bundle for led_pwm_bank: the CPU side drives the request,
// the peripheral returns a one-cycle ready with read data.
interface led_pwm_bank_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/led_pwm_bank.sv
`timescale 1ns/1ps
// led_pwm_bank: iomem-mapped bank of LED drivers, per channel off/on/PWM/blink.
// Define LED_BREATHE_EN to add mode 4 (breathe) driven by a shared triangle ramp.
module led_pwm_bank #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned BLINK_BITS = 6
) (
  input  logic                clk,
  input  logic                resetn,
  led_pwm_bank_if.slave       bus,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int unsigned     PSW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0]  PRESC_MAX = PSW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_PWM     = 3'd2,
    MODE_BLINK   = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_e;

  logic [PSW-1:0]        presc_q, presc_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [PWM_BITS-1:0]   duty_req_q [NUM_LEDS];
  logic [PWM_BITS-1:0]   duty_req_d [NUM_LEDS];
  logic [PWM_BITS-1:0]   duty_act_q [NUM_LEDS];
  logic [2:0]            mode_q     [NUM_LEDS];
  logic [2:0]            mode_d     [NUM_LEDS];
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;

  logic        tick, wrap, access, is_write;
  logic [3:0]  widx;
  logic [31:0] cur_word, new_word;
  logic        unused_bits;

  assign tick     = (presc_q == PRESC_MAX);
  assign wrap     = tick && (&pwm_cnt_q);
  assign access   = bus.iomem_valid && !ready_q;
  assign is_write = (bus.iomem_wstrb != 4'b0000);
  assign widx     = bus.iomem_addr[5:2];

  assign unused_bits = ^{bus.iomem_addr[31:6], bus.iomem_addr[1:0], new_word};

  always_comb begin
    cur_word = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (32'(widx) == i) begin
        cur_word[PWM_BITS-1:0] = duty_req_q[i];
        cur_word[18:16]        = mode_q[i];
      end
    end
  end

  // Merge strobed bytes over the current contents so each field updates per byte.
  always_comb begin
    new_word = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (bus.iomem_wstrb[b]) new_word[8*b +: 8] = bus.iomem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    ready_d = access;
    rdata_d = access ? cur_word : rdata_q;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty_req_d[i] = duty_req_q[i];
      mode_d[i]     = mode_q[i];
      if (access && is_write && (32'(widx) == i)) begin
        duty_req_d[i] = new_word[PWM_BITS-1:0];
        mode_d[i]     = new_word[18:16];
      end
    end
  end

  always_comb begin
    presc_d   = tick ? '0 : presc_q + PSW'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    blink_d   = wrap ? blink_q + BLINK_BITS'(1) : blink_q;
  end

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                ramp_down_q, ramp_down_d;

  // Triangle ramp: each extreme is held for exactly one period before reversing.
  always_comb begin
    ramp_d      = ramp_q;
    ramp_down_d = ramp_down_q;
    if (wrap) begin
      if (!ramp_down_q) begin
        ramp_d = ramp_q + PWM_BITS'(1);
        if (&ramp_d) ramp_down_d = 1'b1;
      end else begin
        ramp_d = ramp_q - PWM_BITS'(1);
        if (ramp_d == '0) ramp_down_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ramp_q      <= '0;
      ramp_down_q <= 1'b0;
    end else begin
      ramp_q      <= ramp_d;
      ramp_down_q <= ramp_down_d;
    end
  end
`endif

  always_comb begin
    leds_d = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      case (mode_q[i])
        MODE_ON:      leds_d[i] = 1'b1;
        MODE_PWM:     leds_d[i] = (pwm_cnt_q < duty_act_q[i]);
        MODE_BLINK:   leds_d[i] = blink_q[BLINK_BITS-1];
`ifdef LED_BREATHE_EN
        MODE_BREATHE: leds_d[i] = (pwm_cnt_q < ramp_q);
`endif
        default:      leds_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      blink_q   <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      leds_q    <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        duty_req_q[i] <= '0;
        duty_act_q[i] <= '0;
        mode_q[i]     <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      blink_q   <= blink_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      leds_q    <= leds_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        duty_req_q[i] <= duty_req_d[i];
        mode_q[i]     <= mode_d[i];
        // Shadow loads the pre-write request, so a write on the wrap edge waits a period.
        if (wrap) duty_act_q[i] <= duty_req_q[i];
      end
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign leds            = leds_q;

endmodule
